// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//   OP_*  : operation encodings carried on the 2-bit op port.
//   ST_*  : control FSM states of shift_seq.
//   DW/SW : default data width and shift-amount width (SW = clog2(DW)).
// Optional feature macro used by the family: SHIFT_SEQ_ROTR_EN.
package shift_pkg;

  localparam int DW = 32;
  localparam int SW = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One step of the shift datapath: shifts acc by 1 or 2 bits according to op.
// Purely combinational; shift_seq iterates it once per RUN cycle.
// Ports:
//   acc  in  DW  value to shift
//   op   in  2   SLL / SRL / SRA / ROTR encoding (see shift_pkg)
//   two  in  1   0 = shift by 1, 1 = shift by 2
//   res  out DW  shifted value
// Macro SHIFT_SEQ_ROTR_EN: when defined op=11 rotates right; otherwise op=11
// passes acc through unchanged (shift_seq never runs a step for it then).
module shift_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] acc,
  input  logic [1:0]    op,
  input  logic          two,
  output logic [DW-1:0] res
);

  import shift_pkg::*;

  // NOTE: every output of an always_comb block is given a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    res = acc;
    if (two) begin
      case (op)
        OP_SLL:  res = {acc[DW-3:0], 2'b00};
        OP_SRL:  res = {2'b00, acc[DW-1:2]};
        OP_SRA:  res = {{2{acc[DW-1]}}, acc[DW-1:2]};
`ifdef SHIFT_SEQ_ROTR_EN
        OP_ROTR: res = {acc[1:0], acc[DW-1:2]};
`endif
        default: res = acc;
      endcase
    end else begin
      case (op)
        OP_SLL:  res = {acc[DW-2:0], 1'b0};
        OP_SRL:  res = {1'b0, acc[DW-1:1]};
        OP_SRA:  res = {acc[DW-1], acc[DW-1:1]};
`ifdef SHIFT_SEQ_ROTR_EN
        OP_ROTR: res = {acc[0], acc[DW-1:1]};
`endif
        default: res = acc;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer for the execute stage (SLL/SRL/SRA, optional
// ROTR). Consumes the shift amount at up to 2 bits per clock through
// shift_step instead of a full barrel shifter.
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   synchronous active-low reset
//   start  in  1   request strobe, only sampled in IDLE
//   op     in  2   00 SLL, 01 SRL, 10 SRA, 11 ROTR / pass-through
//   shamt  in  SW  shift amount
//   din    in  DW  operand
//   busy   out 1   high in RUN
//   done   out 1   one-cycle pulse, dout valid
//   dout   out DW  result, updated only when done rises
// Macro SHIFT_SEQ_ROTR_EN: defined -> op=11 rotates right; undefined ->
// op=11 returns din after one cycle regardless of shamt.
module shift_seq #(
  parameter int DW = 32,
  parameter int SW = 5   // must equal clog2(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [SW-1:0] shamt,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dout
);

  import shift_pkg::*;

  state_e        state, state_nx;
  logic [DW-1:0] acc, acc_nx, step_res;
  logic [SW-1:0] cnt, cnt_nx;
  logic [1:0]    op_q, op_nx;
  logic          step_two;
  logic          pass;
  logic          done_nx;

  // Take a 2-bit step whenever at least two bits remain, so cnt never wraps.
  assign step_two = (cnt >= SW'(2));

  shift_step #(.DW(DW)) u_step (
    .acc (acc),
    .op  (op_q),
    .two (step_two),
    .res (step_res)
  );

  // Requests that need no stepping go straight to DONE with din as result.
  always_comb begin
`ifdef SHIFT_SEQ_ROTR_EN
    pass = (shamt == '0);
`else
    pass = (shamt == '0) || (op == OP_ROTR);
`endif
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    op_nx    = op_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_nx   = din;
          cnt_nx   = shamt;
          op_nx    = op;
          state_nx = pass ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_nx = step_res;
        cnt_nx = cnt - (step_two ? SW'(2) : SW'(1));
        if (cnt_nx == '0) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // done and dout are registered on entry to DONE so they appear in that cycle.
    done_nx = (state_nx == ST_DONE);
  end

  assign busy = (state == ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_q  <= 2'b00;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      op_q  <= op_nx;
      done  <= done_nx;
      if (done_nx) dout <= acc_nx;
    end
  end

endmodule
